// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the ALU operation sequencer.
//   op_e    - ALU opcodes as carried on req_op / alu_ctrl.
//   state_e - sequencer FSM states.
//   is_legal_op() - 1 for opcodes the ALU implements (000..100).
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_SLL = 3'b011,
    OP_SRL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL_WAIT,
    RESP
  } state_e;

  // Opcodes are dense from 000 upward, so legality is a range test.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'(OP_SRL));
  endfunction

endpackage

// File: rtl/alu_seq_wdog.sv
// alu_seq_wdog: multiply timeout counter for the ALU sequencer.
// Only instantiated when ALU_SEQ_MUL_TIMEOUT_EN is defined.
//   clk, reset   - clock, synchronous active-low reset
//   clr          - restart the count (multiply accepted this cycle)
//   run          - sequencer is in MUL_WAIT this cycle
//   expired      - this is the MUL_TIMEOUT-th MUL_WAIT cycle
module alu_seq_wdog #(
  parameter int MUL_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count is 0 in the first MUL_WAIT cycle and saturates on the last one,
  // so MUL_WAIT lasts at most MUL_TIMEOUT cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end sequencing the shared ALU
// (add, sub, multi-cycle mul, sll, srl) for one requester, one op in flight.
//
// Ports:
//   clk, reset            - clock; synchronous active-low reset
//   req_valid/req_ready   - request handshake; req_op, req_a, req_b payload
//   alu_ctrl, alu_a/b     - registered control/operands to the ALU
//   mul_start             - one-cycle multiply start pulse
//   alu_result, alu_hi    - ALU result / multiply high word
//   mul_valid             - multiplier product valid
//   rsp_valid/rsp_ready   - response handshake; rsp_result, rsp_hi, rsp_err
//
// Optional: define ALU_SEQ_MUL_TIMEOUT_EN to abort a multiply that has not
// produced mul_valid within MUL_TIMEOUT MUL_WAIT cycles (rsp_err=1).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             mul_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic             mul_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             mul_start_q, mul_start_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
  logic             rsp_err_q, rsp_err_d;

  logic mul_done;
  logic mul_to;

  // mul_start_q is high exactly in the first MUL_WAIT cycle; a mul_valid
  // there is a leftover from a previous product and must not complete us.
  assign mul_done = (state_q == MUL_WAIT) && !mul_start_q && mul_valid;

`ifdef ALU_SEQ_MUL_TIMEOUT_EN
  logic mul_accept;
  logic wdog_expired;

  assign mul_accept = (state_q == IDLE) && req_valid && (req_op == OP_MUL);

  alu_seq_wdog #(
    .MUL_TIMEOUT(MUL_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (mul_accept),
    .run    (state_q == MUL_WAIT),
    .expired(wdog_expired)
  );

  // A product arriving on the last allowed cycle still wins over the abort.
  assign mul_to = wdog_expired && !mul_done;
`else
  assign mul_to = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    mul_start_d  = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!is_legal_op(req_op)) begin
            // Illegal ops never reach the ALU; answer directly.
            rsp_result_d = '0;
            rsp_hi_d     = '0;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end else begin
            alu_ctrl_d = req_op;
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            if (req_op == OP_MUL) begin
              mul_start_d = 1'b1;
              state_d     = MUL_WAIT;
            end else begin
              state_d = EXEC;
            end
          end
        end
      end

      EXEC: begin
        rsp_result_d = alu_result;
        rsp_hi_d     = '0;
        rsp_err_d    = 1'b0;
        state_d      = RESP;
      end

      MUL_WAIT: begin
        if (mul_done) begin
          rsp_result_d = alu_result;
          rsp_hi_d     = alu_hi;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end else if (mul_to) begin
          rsp_result_d = '0;
          rsp_hi_d     = '0;
          rsp_err_d    = 1'b1;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      mul_start_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_hi_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      mul_start_q  <= mul_start_d;
      rsp_result_q <= rsp_result_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Gate with the live reset so req_ready is 0 for the whole reset window,
  // including before the first clock edge has initialised state_q.
  assign req_ready  = reset && (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign mul_start  = mul_start_q;
  assign rsp_result = rsp_result_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int W  = 32;
  localparam int MT = 8;
`ifdef ALU_SEQ_MUL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk, reset;
  logic         req_valid, req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b;
  logic         mul_start;
  logic [W-1:0] alu_result, alu_hi;
  logic         mul_valid;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result, rsp_hi;
  logic         rsp_err;

  alu_op_sequencer #(.WIDTH(W), .MUL_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .mul_start(mul_start),
    .alu_result(alu_result), .alu_hi(alu_hi), .mul_valid(mul_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_hi(rsp_hi), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: combinational result from whatever the DUT drives.
  logic [63:0] prod;
  assign prod   = {32'b0, alu_a} * {32'b0, alu_b};
  assign alu_hi = prod[63:32];
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = prod[31:0];
      3'd3:    alu_result = alu_a << alu_b;
      3'd4:    alu_result = alu_a >> alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    int          n;      // cycle after accept on which mul_valid is shown
    int          bp;     // cycles rsp_ready is held low once rsp_valid seen
    bit          stale;  // mul_valid already high at accept / first cycle
    logic [31:0] er, eh;
    logic        ee;
    int          elat;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int last_acc = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: expected response from the operation's definition.
  function automatic void exp_of(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int n,
                                 output logic [31:0] r, output logic [31:0] h,
                                 output logic e, output int lat);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    h = '0; e = 1'b0; lat = 2;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: begin r = p[31:0]; h = p[63:32]; lat = n + 1; end
      3'd3: r = (b >= 32) ? 32'd0 : (a << b[4:0]);
      3'd4: r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
      default: begin r = '0; e = 1'b1; lat = 1; end
    endcase
    if (TO_EN && op == 3'd2 && n > MT) begin
      r = '0; h = '0; e = 1'b1; lat = MT + 1;
    end
  endfunction

  // Starts and ends on a negedge with the DUT idle.
  task automatic do_txn(input vec_t v, input string tag);
    int lat = 0, ms_cnt = 0, drive_bad = 0, busy_bad = 0;
    bit ms_first = 0, got = 0;
    logic [31:0] gr = '0, gh = '0;
    logic ge = 1'b0;
    check({tag, ".req_ready_idle"}, req_ready, 1);
    last_acc  = cyc;
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    mul_valid = v.stale; rsp_ready = 1'b0;
    @(posedge clk);
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (mul_start) begin ms_cnt++; if (lat == 1) ms_first = 1; end
      if (req_ready) busy_bad++;
      if (rsp_valid) begin
        got = 1; gr = rsp_result; gh = rsp_hi; ge = rsp_err;
        mul_valid = 1'b0;
        break;
      end
      if (v.op <= 3'd4 && (alu_ctrl !== v.op || alu_a !== v.a || alu_b !== v.b))
        drive_bad++;
      if (v.op == 3'd2) mul_valid = (lat == v.n) || (v.stale && lat == 1);
      else              mul_valid = 1'($urandom_range(0, 1));
    end
    check({tag, ".rsp_seen"}, got, 1);
    check({tag, ".latency"}, lat, v.elat);
    check({tag, ".rsp_result"}, gr, v.er);
    check({tag, ".rsp_hi"}, gh, v.eh);
    check({tag, ".rsp_err"}, ge, v.ee);
    check({tag, ".mul_start_cnt"}, ms_cnt, (v.op == 3'd2) ? 1 : 0);
    check({tag, ".mul_start_first"}, ms_first, (v.op == 3'd2) ? 1 : 0);
    check({tag, ".alu_drive_stable"}, drive_bad, 0);
    check({tag, ".req_ready_busy"}, busy_bad, 0);
    for (int k = 0; k < v.bp; k++) begin
      @(negedge clk);
      mul_valid = 1'($urandom_range(0, 1));
      check({tag, ".bp_rsp_valid"}, rsp_valid, 1);
      check({tag, ".bp_rsp_result"}, rsp_result, v.er);
      check({tag, ".bp_rsp_err"}, rsp_err, v.ee);
      check({tag, ".bp_req_ready"}, req_ready, 0);
    end
    mul_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_retired"}, rsp_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".req_ready"}, req_ready, 0);
    check({tag, ".rsp_valid"}, rsp_valid, 0);
    check({tag, ".rsp_result"}, rsp_result, 0);
    check({tag, ".rsp_hi"}, rsp_hi, 0);
    check({tag, ".rsp_err"}, rsp_err, 0);
    check({tag, ".mul_start"}, mul_start, 0);
    check({tag, ".alu_ctrl"}, alu_ctrl, 0);
    check({tag, ".alu_ab"}, {alu_a, alu_b}, 0);
  endtask

  // Idle with mul_valid high: nothing may respond.
  task automatic idle_ignore(input string tag);
    mul_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, ".rsp_valid"}, rsp_valid, 0);
      check({tag, ".req_ready"}, req_ready, 1);
    end
    mul_valid = 1'b0;
  endtask

  vec_t tab [8];
  int   ntab;

  initial begin
    vec_t v;
    int t1;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    mul_valid = 1'b0; rsp_ready = 1'b0;

    //        op     a             b             n     bp stale er             eh     ee   elat
    tab[0] = '{3'd0, 32'd5,        32'd7,        0,    0, 0,    32'd12,        32'd0, 1'b0, 2};
    tab[1] = '{3'd1, 32'd3,        32'd5,        0,    4, 0,    32'hFFFF_FFFE, 32'd0, 1'b0, 2};
    tab[2] = '{3'd6, 32'd9,        32'd9,        0,    0, 0,    32'd0,         32'd0, 1'b1, 1};
    tab[3] = '{3'd3, 32'd1,        32'd40,       0,    0, 0,    32'd0,         32'd0, 1'b0, 2};
    tab[4] = '{3'd4, 32'h8000_0000, 32'd31,      0,    1, 0,    32'd1,         32'd0, 1'b0, 2};
    tab[5] = '{3'd7, 32'd1,        32'd2,        0,    2, 0,    32'd0,         32'd0, 1'b1, 1};
`ifdef ALU_SEQ_MUL_TIMEOUT_EN
    tab[6] = '{3'd2, 32'h1_0000,   32'h1_0000,   6,    0, 1,    32'd0,         32'd1, 1'b0, 7};
    tab[7] = '{3'd2, 32'd3,        32'd4,        1000, 0, 0,    32'd0,         32'd0, 1'b1, MT + 1};
    ntab = 8;
`else
    tab[6] = '{3'd2, 32'h1_0000,   32'h1_0000,   34,   0, 1,    32'd0,         32'd1, 1'b0, 35};
    ntab = 7;
`endif

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    check("reset_release.req_ready", req_ready, 1);

    for (int i = 0; i < ntab; i++)
      do_txn(tab[i], $sformatf("tab%0d", i));

    // Late mul_valid after a response (and after a timeout, when enabled).
    idle_ignore("late_mul_valid");

    // Back-to-back adds: accepts exactly 3 cycles apart.
    v = '{3'd0, 32'd1, 32'd2, 0, 0, 0, 32'd3, 32'd0, 1'b0, 2};
    do_txn(v, "b2b_a");
    t1 = last_acc;
    v = '{3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 32'd1, 32'd0, 1'b0, 2};
    do_txn(v, "b2b_b");
    check("accept_interval", last_acc - t1, 3);

    // Reset while in MUL_WAIT aborts the multiply.
    req_valid = 1'b1; req_op = 3'd2; req_a = 32'd2; req_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midop_reset");
    reset = 1'b1;
    idle_ignore("post_reset_mul_valid");
    v = '{3'd0, 32'd100, 32'd23, 0, 0, 0, 32'd123, 32'd0, 1'b0, 2};
    do_txn(v, "post_reset_add");

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      v.op    = 3'($urandom_range(0, 7));
      v.a     = $urandom;
      v.b     = (v.op == 3'd3 || v.op == 3'd4) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 3) == 0) v.a = 32'($urandom_range(0, 16));
      v.n     = TO_EN ? $urandom_range(2, MT + 3) : $urandom_range(2, 12);
      v.bp    = $urandom_range(0, 3);
      v.stale = 1'($urandom_range(0, 1));
      exp_of(v.op, v.a, v.b, v.n, v.er, v.eh, v.ee, v.elat);
      do_txn(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
